if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage, directly upstream of the decode stage.
- Owns the architectural fetch PC and computes next-PC from the redirect, stall and decode-target inputs.
- Drives the synchronous-read BIOS and IMEM address/enable ports so the selected instruction appears at the memory outputs one cycle later, aligned with id_pc.
- Also keeps fetch performance counters and a sticky misaligned-target flag.

Parameters:
RESET_PC, 32'h4000_0000, PC loaded during reset (BIOS entry).
BIOS_AW, 12, BIOS word-address width.
IMEM_AW, 14, IMEM word-address width.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
ex_flush  input  1  EX-stage mispredict/redirect, highest priority after rst
ex_pc_target  input  32  redirect PC accompanying ex_flush
id_stall  input  1  decode hazard stall; hold PC
if_target_taken  input  1  decode-stage target valid
if_pc_target  input  32  decode-stage target PC
id_pc  output  32  PC of the instruction currently at the memory outputs (to decode)
bios_addr  output  BIOS_AW  BIOS word address
bios_en  output  1  BIOS read enable
imem_addr  output  IMEM_AW  IMEM word address
imem_en  output  1  IMEM read enable
fetch_count  output  32  instructions passed to decode
redirect_count  output  32  accepted decode-target redirects
flush_count  output  32  accepted EX flushes
if_misaligned  output  1  sticky: a non-word-aligned PC was loaded

Behaviour:
- Single register fetch_pc drives id_pc. next_pc is combinational and is the only source of memory addresses.
- next_pc priority, highest first:
  - rst -> RESET_PC
  - ex_flush -> ex_pc_target
  - id_stall -> fetch_pc
  - if_target_taken -> if_pc_target
  - else fetch_pc + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0)
- fetch_pc <= next_pc every cycle.
- Stall vs. target: stall beats if_target_taken. Decode re-presents the target after the stall clears.
- Flush vs. stall: ex_flush beats id_stall.
- Addressing:
  - bios_addr = next_pc[BIOS_AW+1:2]; imem_addr = next_pc[IMEM_AW+1:2]. Both are always driven.
  - Region select: next_pc[30]=1 is BIOS, 0 is IMEM.
  - bios_en = next_pc[30] & ~hold; imem_en = ~next_pc[30] & ~hold.
  - hold = id_stall & ~ex_flush & ~rst. While held, the memories keep their previous output, so decode sees the same instruction.
- Latency: address presented in cycle t; instruction valid in cycle t+1, when id_pc = that address. A redirect therefore causes zero fetch bubbles in IF; squashing is decode/EX responsibility.
- Reset:
  - During rst, memories are enabled at RESET_PC. The first post-reset cycle has id_pc = RESET_PC with a valid instruction.
  - Reset values: id_pc = RESET_PC; all counters = 0; if_misaligned = 0.
  - rst asserted mid-stall or mid-flush overrides everything that cycle.
- Counters:
  - Each is 32-bit, wraps at 2^32 - 1 -> 0, increments by at most 1 per cycle, and is not incremented while rst.
  - fetch_count: +1 when ~id_stall & ~ex_flush.
  - redirect_count: +1 when if_target_taken & ~id_stall & ~ex_flush.
  - flush_count: +1 when ex_flush.
- if_misaligned: set when ~rst and next_pc[1:0] != 0. Cleared only by rst. The PC is still loaded unmodified, with no fault trap in this block.

Test Plan:
- Reset release, no stalls: 4 cycles -> id_pc 4000_0000, 4000_0004, 4000_0008, 4000_000C; bios_en=1, imem_en=0; fetch_count=4.
- id_stall for 3 cycles at id_pc=4000_0008 -> id_pc holds; bios_en=0 throughout; fetch_count frozen; releases to 4000_000C next cycle.
- if_target_taken with if_pc_target=1000_0000 -> next cycle id_pc=1000_0000; imem_en=1 and imem_addr=0 in the redirect cycle; redirect_count +1. Same stimulus with id_stall=1 -> no redirect, count unchanged.
- ex_flush=1 (ex_pc_target=1000_0040) concurrently with id_stall=1 and if_target_taken (target 1000_0100) -> id_pc=1000_0040; flush_count +1; redirect_count and fetch_count unchanged.
- Target 1000_0002 -> if_misaligned=1 and stays 1 across later aligned fetches until rst.
- Preloaded fetch_pc=FFFF_FFFC by redirect, no stall -> next id_pc=0000_0000. Counter preset to FFFF_FFFF via forced value -> wraps to 0.

Source files
------------

// File: rtl/if_stage_if.sv
// if_stage_if: bundles the pipeline-control inputs, the instruction-memory
// address/enable bus and the status/counter outputs of the fetch stage.
//   master : used by if_stage (drives id_pc, memory ports, counters, flag)
//   slave  : used by the surrounding pipeline / testbench
// Parameters BIOS_AW / IMEM_AW size the BIOS and IMEM word addresses.
interface if_stage_if #(
  parameter int BIOS_AW = 12,
  parameter int IMEM_AW = 14
);
  logic               ex_flush;
  logic [31:0]        ex_pc_target;
  logic               id_stall;
  logic               if_target_taken;
  logic [31:0]        if_pc_target;
  logic [31:0]        id_pc;
  logic [BIOS_AW-1:0] bios_addr;
  logic               bios_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic               imem_en;
  logic [31:0]        fetch_count;
  logic [31:0]        redirect_count;
  logic [31:0]        flush_count;
  logic               if_misaligned;

  modport master (
    input  ex_flush, ex_pc_target, id_stall, if_target_taken, if_pc_target,
    output id_pc, bios_addr, bios_en, imem_addr, imem_en,
           fetch_count, redirect_count, flush_count, if_misaligned
  );

  modport slave (
    output ex_flush, ex_pc_target, id_stall, if_target_taken, if_pc_target,
    input  id_pc, bios_addr, bios_en, imem_addr, imem_en,
           fetch_count, redirect_count, flush_count, if_misaligned
  );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage.
// Owns the fetch PC, selects the next PC (reset > EX flush > decode stall >
// decode target > sequential +4) and presents it as the address of the
// synchronous-read BIOS / IMEM, so the instruction is at the memory outputs
// one cycle later, aligned with id_pc. Also keeps fetch/redirect/flush
// counters and a sticky misaligned-PC flag.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - if_stage_if.master (pipeline controls in; id_pc, memory address
//          and enables, counters and if_misaligned out)
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter int          BIOS_AW  = 12,
  parameter int          IMEM_AW  = 14
) (
  input  logic         clk,
  input  logic         rst,
  if_stage_if.master   bus
);

  logic [31:0] fetch_pc_reg;
  logic [31:0] next_pc;
  logic        hold;
  logic        fetch_ok;

  logic [31:0] fetch_count_reg;
  logic [31:0] redirect_count_reg;
  logic [31:0] flush_count_reg;
  logic        misaligned_reg;

  // Next-PC selection; this is the sole source of the memory addresses.
  always_comb begin
    next_pc = fetch_pc_reg + 32'd4;
    if (rst)
      next_pc = RESET_PC;
    else if (bus.ex_flush)
      next_pc = bus.ex_pc_target;
    else if (bus.id_stall)
      next_pc = fetch_pc_reg;
    else if (bus.if_target_taken)
      next_pc = bus.if_pc_target;
  end

  // While held the memories are disabled so their outputs (and therefore the
  // instruction seen by decode) stay unchanged.
  assign hold     = bus.id_stall & ~bus.ex_flush & ~rst;
  assign fetch_ok = ~bus.id_stall & ~bus.ex_flush;

  assign bus.bios_addr = next_pc[BIOS_AW+1:2];
  assign bus.imem_addr = next_pc[IMEM_AW+1:2];
  assign bus.bios_en   =  next_pc[30] & ~hold;
  assign bus.imem_en   = ~next_pc[30] & ~hold;

  always_ff @(posedge clk) begin
    fetch_pc_reg <= next_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_reg    <= 32'd0;
      redirect_count_reg <= 32'd0;
      flush_count_reg    <= 32'd0;
      misaligned_reg     <= 1'b0;
    end else begin
      if (fetch_ok)
        fetch_count_reg <= fetch_count_reg + 32'd1;
      if (fetch_ok & bus.if_target_taken)
        redirect_count_reg <= redirect_count_reg + 32'd1;
      if (bus.ex_flush)
        flush_count_reg <= flush_count_reg + 32'd1;
      // The PC is loaded unmodified; misalignment is only recorded here.
      if (next_pc[1:0] != 2'b00)
        misaligned_reg <= 1'b1;
    end
  end

  assign bus.id_pc          = fetch_pc_reg;
  assign bus.fetch_count    = fetch_count_reg;
  assign bus.redirect_count = redirect_count_reg;
  assign bus.flush_count    = flush_count_reg;
  assign bus.if_misaligned  = misaligned_reg;

endmodule
